// File: rtl/sram_test_pkg.sv
// Shared state encodings for the SRAM test sequencer and the debug/LED top level.
package sram_test_pkg;

    localparam int unsigned StateBits = 3;

    typedef enum logic [StateBits-1:0] {
        StIdle  = 3'd0,
        StWrite = 3'd1,
        StRead  = 3'd2,
        StDrain = 3'd3,
        StNext  = 3'd4,
        StDone  = 3'd5,
        StHalt  = 3'd6
    } test_state_e;

    // Width of a counter indexing n items, never narrower than one bit.
    function automatic int unsigned min_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_read_check_pipe.sv
// Valid/address shift register that lines the checker strobe up with returned read data.
module sram_read_check_pipe #(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned ADDR_BITS = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    output logic                 valid_o,
    output logic [ADDR_BITS-1:0] addr_o
);

    logic [LATENCY-1:0]                valid_q;
    logic [LATENCY-1:0][ADDR_BITS-1:0] addr_q;

    // Shift one stage per cycle; a flush kills every in-flight entry at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            addr_q  <= '0;
        end else begin
            valid_q[0] <= push_i & ~flush_i;
            addr_q[0]  <= addr_i;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1] & ~flush_i;
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign addr_o  = addr_q[LATENCY-1];

endmodule

// File: rtl/sram_test_sequencer.sv
// Write/read-back pass sequencer over an SRAM address range, with latency-aligned checking.
module sram_test_sequencer
    import sram_test_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 20,
    parameter int unsigned ADDR_LAST    = 2**ADDR_BITS - 1,
    parameter int unsigned NUM_PATTERNS = 4,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ITERATIONS   = 1,
    parameter int unsigned ERR_CNT_BITS = 16,
    localparam int unsigned PAT_BITS    = min_bits(NUM_PATTERNS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    halt_on_fail_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    passed_o,
    output logic [ERR_CNT_BITS-1:0] err_count_o,
    output logic [15:0]             iter_count_o,
    output logic [StateBits-1:0]    test_state_o,
    output logic [ADDR_BITS-1:0]    mem_addr_o,
    output logic                    mem_we_o,
    output logic                    mem_re_o,
    output logic [PAT_BITS-1:0]     pattern_idx_o,
    output logic                    check_valid_o,
    output logic [ADDR_BITS-1:0]    check_addr_o,
    input  logic                    mismatch_i
);

    localparam int unsigned DrainBits = min_bits(READ_LATENCY);
    localparam logic [ADDR_BITS-1:0] AddrLast  = ADDR_BITS'(ADDR_LAST);
    localparam logic [PAT_BITS-1:0]  PatLast   = PAT_BITS'(NUM_PATTERNS - 1);
    localparam logic [DrainBits-1:0] DrainLast = DrainBits'(READ_LATENCY - 1);

    test_state_e             state_q, state_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [PAT_BITS-1:0]     pat_q, pat_d;
    logic [ERR_CNT_BITS-1:0] err_q, err_d;
    logic [15:0]             iter_q, iter_d;
    logic [DrainBits-1:0]    drain_q, drain_d;
    logic                    halt_mode_q, halt_mode_d;
    logic                    push, flush, hit, busy, final_iter;

    assign busy       = state_q inside {StWrite, StRead, StDrain, StNext};
    assign hit        = check_valid_o & mismatch_i & busy;
    assign final_iter = (ITERATIONS != 0) && ((32'(iter_q) + 32'd1) == ITERATIONS);

    // Next-state, counters and pipe control; a halting mismatch overrides any transition.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pat_d       = pat_q;
        err_d       = err_q;
        iter_d      = iter_q;
        drain_d     = drain_q;
        halt_mode_d = halt_mode_q;
        push        = 1'b0;
        flush       = 1'b0;
        unique case (state_q)
            StIdle, StDone, StHalt: begin
                if (start_i) begin
                    state_d     = StWrite;
                    addr_d      = '0;
                    pat_d       = '0;
                    err_d       = '0;
                    iter_d      = '0;
                    halt_mode_d = halt_on_fail_i;
                end
            end
            StWrite: begin
                if (addr_q == AddrLast) begin
                    addr_d  = '0;
                    state_d = StRead;
                end else begin
                    addr_d = addr_q + ADDR_BITS'(1);
                end
            end
            StRead: begin
                push = 1'b1;
                if (addr_q == AddrLast) begin
                    addr_d  = '0;
                    drain_d = '0;
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + ADDR_BITS'(1);
                end
            end
            StDrain: begin
                drain_d = drain_q + DrainBits'(1);
                if (drain_q == DrainLast) begin
                    // Pattern/iteration advance is visible during NEXT (or DONE).
                    if (pat_q == PatLast) begin
                        pat_d   = '0;
                        iter_d  = (iter_q != 16'hFFFF) ? iter_q + 16'd1 : iter_q;
                        state_d = final_iter ? StDone : StNext;
                    end else begin
                        pat_d   = pat_q + PAT_BITS'(1);
                        state_d = StNext;
                    end
                end
            end
            StNext: begin
                addr_d  = '0;
                state_d = StWrite;
            end
            default: state_d = StIdle;
        endcase
        if (hit) begin
            if (err_q != '1) begin
                err_d = err_q + ERR_CNT_BITS'(1);
            end
            if (halt_mode_q) begin
                state_d = StHalt;
                pat_d   = pat_q;
                iter_d  = iter_q;
                flush   = 1'b1;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            pat_q       <= '0;
            err_q       <= '0;
            iter_q      <= '0;
            drain_q     <= '0;
            halt_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pat_q       <= pat_d;
            err_q       <= err_d;
            iter_q      <= iter_d;
            drain_q     <= drain_d;
            halt_mode_q <= halt_mode_d;
        end
    end

    sram_read_check_pipe #(
        .LATENCY  (READ_LATENCY),
        .ADDR_BITS(ADDR_BITS)
    ) u_pipe (
        .clk    (clk),
        .reset  (reset),
        .flush_i(flush),
        .push_i (push),
        .addr_i (addr_q),
        .valid_o(check_valid_o),
        .addr_o (check_addr_o)
    );

    // Status and strobes decoded straight from the registered state.
    always_comb begin
        busy_o        = busy;
        done_o        = (state_q == StDone) || (state_q == StHalt);
        passed_o      = (state_q == StDone) && (err_q == '0);
        mem_we_o      = (state_q == StWrite);
        mem_re_o      = (state_q == StRead);
        err_count_o   = err_q;
        iter_count_o  = iter_q;
        test_state_o  = state_q;
        mem_addr_o    = addr_q;
        pattern_idx_o = pat_q;
    end

endmodule

// File: tb/tb_sram_test_sequencer.sv
// Bench: two sequencer instances (one-shot and run-forever) against a cycle-position model.
module tb_sram_test_sequencer;

    localparam int NADDR = 8;
    localparam int LAT   = 2;
    localparam int NPAT  = 2;
    localparam int SEG   = 2 * NADDR + LAT + 1;  // write + read + drain + next

    typedef struct packed {
        logic [2:0]  st;
        logic        busy;
        logic        done;
        logic        passed;
        logic        we;
        logic        re;
        logic        cv;
        logic [2:0]  addr;
        logic [2:0]  caddr;
        logic        pat;
        logic [15:0] err;
        logic [15:0] iter;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    logic start_a, halt_a, mism_a, start_b, halt_b, mism_b;

    logic        busy_a, done_a, passed_a, we_a, re_a, cv_a;
    logic [15:0] err_a, iter_a;
    logic [2:0]  st_a, addr_a, caddr_a;
    logic [0:0]  pat_a;
    logic        busy_b, done_b, passed_b, we_b, re_b, cv_b;
    logic [1:0]  err_b;
    logic [15:0] iter_b;
    logic [2:0]  st_b, addr_b, caddr_b;
    logic [0:0]  pat_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_test_sequencer #(
        .ADDR_BITS(3), .ADDR_LAST(7), .NUM_PATTERNS(2), .READ_LATENCY(2),
        .ITERATIONS(1), .ERR_CNT_BITS(16)
    ) u_dut_a (
        .clk(clk), .reset(reset), .start_i(start_a), .halt_on_fail_i(halt_a),
        .busy_o(busy_a), .done_o(done_a), .passed_o(passed_a), .err_count_o(err_a),
        .iter_count_o(iter_a), .test_state_o(st_a), .mem_addr_o(addr_a), .mem_we_o(we_a),
        .mem_re_o(re_a), .pattern_idx_o(pat_a), .check_valid_o(cv_a),
        .check_addr_o(caddr_a), .mismatch_i(mism_a)
    );

    sram_test_sequencer #(
        .ADDR_BITS(3), .ADDR_LAST(7), .NUM_PATTERNS(2), .READ_LATENCY(2),
        .ITERATIONS(0), .ERR_CNT_BITS(2)
    ) u_dut_b (
        .clk(clk), .reset(reset), .start_i(start_b), .halt_on_fail_i(halt_b),
        .busy_o(busy_b), .done_o(done_b), .passed_o(passed_b), .err_count_o(err_b),
        .iter_count_o(iter_b), .test_state_o(st_b), .mem_addr_o(addr_b), .mem_we_o(we_b),
        .mem_re_o(re_b), .pattern_idx_o(pat_b), .check_valid_o(cv_b),
        .check_addr_o(caddr_b), .mismatch_i(mism_b)
    );

    function automatic obs_t pack_obs(input bit use_b);
        obs_t o;
        if (use_b) o = '{st_b, busy_b, done_b, passed_b, we_b, re_b, cv_b, addr_b, caddr_b,
                         pat_b, 16'(err_b), iter_b};
        else       o = '{st_a, busy_a, done_a, passed_a, we_a, re_a, cv_a, addr_a, caddr_a,
                         pat_a, err_a, iter_a};
        return o;
    endfunction

    // Expected outputs in cycle k after the start edge, from the pass timeline.
    function automatic obs_t model(input int k, input int halted_at, input int iters,
                                   input int err);
        obs_t e;
        int idx, p, r;
        e = '0;
        e.err = 16'(err);
        if (halted_at != 0 && k > halted_at) begin
            e.st = 3'd6; e.done = 1'b1;
            return e;
        end
        if (iters != 0 && k >= SEG * NPAT * iters) begin
            e.st = 3'd5; e.done = 1'b1; e.passed = (err == 0); e.iter = 16'(iters);
            return e;
        end
        idx = k - 1; p = idx / SEG; r = idx % SEG;
        e.busy = 1'b1;
        e.iter = 16'(k / (SEG * NPAT));
        if (r < NADDR) begin
            e.st = 3'd1; e.we = 1'b1; e.addr = 3'(r); e.pat = 1'(p % NPAT);
        end else if (r < 2 * NADDR) begin
            e.st = 3'd2; e.re = 1'b1; e.addr = 3'(r - NADDR); e.pat = 1'(p % NPAT);
        end else if (r < 2 * NADDR + LAT) begin
            e.st = 3'd3;
        end else begin
            e.st = 3'd4;
        end
        if (r >= NADDR + LAT && r < 2 * NADDR + LAT) begin
            e.cv = 1'b1; e.caddr = 3'(r - NADDR - LAT);
        end
        return e;
    endfunction

    // Blank fields the expectation leaves undefined.
    function automatic obs_t mask(input obs_t o, input obs_t e);
        obs_t m;
        m = o;
        if (!(e.we || e.re)) begin m.addr = '0; m.pat = 1'b0; end
        if (!e.cv) m.caddr = '0;
        if (e.st == 3'd6) m.iter = '0;
        return m;
    endfunction

    task automatic drive(input bit use_b, input logic s, input logic h, input logic m);
        if (use_b) begin start_b = s; halt_b = h; mism_b = m; end
        else       begin start_a = s; halt_a = h; mism_a = m; end
    endtask

    task automatic check_zero(input bit use_b, input string tag);
        obs_t o;
        o = pack_obs(use_b);
        checks++;
        assert (o === '0) else begin
            errors++;
            $error("FAIL %s dut=%s observed=%h expected=%h", tag, use_b ? "B" : "A", o, obs_t'(0));
        end
    endtask

    task automatic run(input bit use_b, input bit halt, input int pct,
                       input logic [63:0] force_mask, input int ncyc, input int rst_at);
        int hits, halted_at, iters, errmax;
        logic mis, st;
        obs_t e, o;
        hits = 0; halted_at = 0;
        iters  = use_b ? 0 : 1;
        errmax = use_b ? 3 : 65535;
        @(negedge clk);
        drive(use_b, 1'b1, halt, 1'b0);
        @(posedge clk); #1;
        for (int k = 1; k <= ncyc; k++) begin
            e = model(k, halted_at, iters, (hits > errmax) ? errmax : hits);
            o = mask(pack_obs(use_b), e);
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL cycle dut=%s k=%0d observed=%h expected=%h",
                       use_b ? "B" : "A", k, o, e);
            end
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                check_zero(use_b, "async_reset");
                @(negedge clk);
                reset = 1'b0;
                drive(use_b, 1'b0, 1'b0, 1'b0);
                return;
            end
            mis = (k < 64 ? force_mask[k] : 1'b0) || ($urandom_range(99) < pct);
            st  = e.busy && ($urandom_range(3) == 0);
            drive(use_b, st, 1'($urandom_range(1)), mis);
            if (halted_at == 0 && e.cv && mis) begin
                hits++;
                if (halt) halted_at = k;
            end
            @(posedge clk); #1;
        end
        drive(use_b, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_zero(1'b0, "reset_a");
        check_zero(1'b1, "reset_b");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_zero(1'b0, "idle_a");
        // clean pass
        run(1'b0, 1'b0, 0, 64'h0, 45, 0);
        // continue mode, directed mismatches at addr 2, 5 (pattern 0) and 7 (pattern 1)
        run(1'b0, 1'b0, 0, (64'h1 << 13) | (64'h1 << 16) | (64'h1 << 37), 45, 0);
        // continue mode, random mismatches
        run(1'b0, 1'b0, 30, 64'h0, 45, 0);
        // halt mode, mismatch at addr 5 pattern 0, then hold in HALT
        run(1'b0, 1'b1, 0, 64'h1 << 16, 25, 0);
        // restart after halt
        run(1'b0, 1'b0, 0, 64'h0, 42, 0);
        // halt on the last drain cycle beats DONE
        run(1'b0, 1'b1, 0, 64'h1 << 37, 42, 0);
        // random halt mode
        run(1'b0, 1'b1, 10, 64'h0, 45, 0);
        // reset during write of pattern 1, then a clean rerun
        run(1'b0, 1'b0, 0, 64'h0, 30, 23);
        run(1'b0, 1'b0, 0, 64'h0, 42, 0);
        // run-forever instance: mismatch held high saturates the 2-bit counter
        run(1'b1, 1'b0, 100, 64'h0, 160, 160);
        // run-forever instance in halt mode with random mismatches
        run(1'b1, 1'b1, 20, 64'h0, 120, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_test_sequencer.md
Name: sram_test_sequencer

Overview:
Parametrised SRAM test sequencer. It steps through NUM_PATTERNS write/read-back passes over addresses 0..ADDR_LAST and repeats for ITERATIONS rounds, or forever when ITERATIONS is 0.
- Has an internal address counter and pattern index.
- Models SRAM read latency and aligns the checker's compare strobe to returned data.
- Runs in one of two modes, halt-on-fail or count-and-continue.
- Sits between the board top level and the SRAM controller, pattern generator and data checker.

Parameters:
ADDR_BITS, 20, SRAM address width
ADDR_LAST, 2**ADDR_BITS-1, last address tested (range 0..ADDR_LAST)
NUM_PATTERNS, 4, patterns per iteration (>=1)
READ_LATENCY, 2, cycles from mem_re to data valid at checker (>=1)
ITERATIONS, 1, full iterations before DONE; 0 = run forever
ERR_CNT_BITS, 16, error counter width
PAT_BITS, $clog2(NUM_PATTERNS) min 1, derived localparam

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
start  in  1  begin test; sampled only in IDLE, DONE, HALT
halt_on_fail  in  1  1 = stop on first mismatch; 0 = count and continue; sampled with start
busy  out  1  high in WRITE/READ/DRAIN/NEXT
done  out  1  high in DONE or HALT
passed  out  1  high in DONE when err_count==0
err_count  out  ERR_CNT_BITS  saturating mismatch count
iter_count  out  16  completed iterations, saturating
test_state  out  3  state encoding (debug)
mem_addr  out  ADDR_BITS  current write/read address
mem_we  out  1  write strobe, one address per cycle
mem_re  out  1  read strobe, one address per cycle
pattern_idx  out  PAT_BITS  active pattern for generator and checker
check_valid  out  1  compare strobe, READ_LATENCY cycles after mem_re
check_addr  out  ADDR_BITS  address whose data is at the checker
mismatch  in  1  checker result; qualified by check_valid in the same cycle

Behaviour:
- Reset values (async): state IDLE, every output 0, counters 0, pipeline cleared.
- States: IDLE=0, WRITE=1, READ=2, DRAIN=3, NEXT=4, DONE=5, HALT=6.
- IDLE/DONE/HALT + start:
  - Next cycle WRITE, addr 0, pattern 0.
  - err_count and iter_count cleared.
  - Mode latched.
  - start is ignored while busy.
- WRITE:
  - mem_we=1 at mem_addr; address increments each cycle.
  - At ADDR_LAST: address goes to 0, next state READ.
- READ:
  - mem_re=1; address increments each cycle.
  - Every read pushes {valid, addr} into a READ_LATENCY-deep shift pipe.
  - At ADDR_LAST: next state DRAIN.
- DRAIN: no strobes; stays until the pipe is empty, exactly READ_LATENCY cycles.
- End of DRAIN:
  - Last pattern and final iteration (iter_count+1==ITERATIONS, ITERATIONS!=0): go to DONE.
  - Otherwise go to NEXT.
- NEXT (one cycle):
  - pattern_idx increments.
  - On wrap to 0, iter_count increments (saturating).
  - Address goes to 0, next state WRITE.
  - In DONE, iter_count equals ITERATIONS.
- mem_we, mem_re and busy are decoded from the registered state; check_valid/check_addr are the pipe output.
- Mismatch (check_valid & mismatch):
  - err_count increments, saturating at all-ones.
  - If halt_on_fail latched: next state HALT. Strobes drop, the pipe is flushed, and later mismatch inputs are ignored.
  - check_valid may still be asserted while in DRAIN; mismatches there are counted.
- A mismatch and the DRAIN exit in the same cycle: HALT wins over DONE/NEXT.
- HALT: done=1, passed=0; held until start or reset.
- DONE: done=1, passed=(err_count==0); held.
- Reset mid-operation: immediate return to the reset state; no partial strobes afterwards.
- Address arithmetic is ADDR_BITS wide. ADDR_LAST==2**ADDR_BITS-1 is legal; the wrap is by compare, not overflow.

Decomposition:
- sram_test_pkg holds the state encodings and the state-width constant, shared with the debug/LED top level.
- Sub-module sram_read_check_pipe: READ_LATENCY-deep valid/address shift register with synchronous flush.

Test Plan:
Common setup for directed runs: ADDR_BITS=3, ADDR_LAST=7, NUM_PATTERNS=2, READ_LATENCY=2, ITERATIONS=1; start sampled at edge 0.
1. Clean pass, mismatch=0:
   - Cycles 1-8 WRITE and 9-16 READ at addrs 0-7, pattern 0.
   - check_valid in cycles 11-18, check_addr 0-7.
   - Cycle 19 NEXT; cycles 20-37 repeat for pattern 1.
   - Cycle 38 onward: done=1, passed=1, iter_count=1, busy=0.
2. Continue mode: mismatch on check_addr 2, 5 (pattern 0) and 7 (pattern 1).
   - Same timing as scenario 1.
   - DONE with err_count=3, passed=0.
3. Halt mode: mismatch at check_addr 5, pattern 0.
   - Next cycle: HALT, mem_re=0, check_valid=0, done=1, passed=0, err_count=1.
   - A later start restarts at WRITE addr 0 with err_count=0.
4. Reset asserted in cycle 23 (WRITE):
   - All outputs 0 and state IDLE immediately.
   - A start after release reproduces scenario 1 timing.
5. ITERATIONS=0: iter_count increments every 38 cycles (cycle 38, 76, ...); done never asserts.
6. ERR_CNT_BITS=2, continue mode, mismatch held high: err_count saturates at 3. Also: start pulses while busy are ignored, with no timing change.
